// File: rtl/vga_pkg.sv
// Shared types, colour constants and frame-geometry helpers for the VGA timing block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package vga_pkg;

    // Test-pattern selector values as seen on pattern_sel_in
    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRID  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_t;

    // 12-bit {R,G,B} nibble colours
    localparam logic [11:0] COL_WHITE   = 12'hFFF;
    localparam logic [11:0] COL_YELLOW  = 12'hFF0;
    localparam logic [11:0] COL_CYAN    = 12'h0FF;
    localparam logic [11:0] COL_GREEN   = 12'h0F0;
    localparam logic [11:0] COL_MAGENTA = 12'hF0F;
    localparam logic [11:0] COL_RED     = 12'hF00;
    localparam logic [11:0] COL_BLUE    = 12'h00F;
    localparam logic [11:0] COL_BLACK   = 12'h000;

    // Pixels per full line including blanking
    function automatic int h_total(input int width, input int front, input int sync, input int back);
        return width + front + sync + back;
    endfunction

    // Lines per full frame including blanking
    function automatic int v_total(input int height, input int front, input int sync, input int back);
        return height + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// Bundle of registered VGA timing/pixel outputs between the generator and the pixel receiver.
// Latency: n/a (wires only).
// Backpressure: none; the receiver must accept every pixel-rate tick.
interface vga_sync_generator_if #(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9,
    parameter int PIXEL_BITS  = 12
);
    logic                   h_sync_out;
    logic                   v_sync_out;
    logic                   video_on_out;
    logic [WIDTH_BITS-1:0]  pixel_x_out;
    logic [HEIGHT_BITS-1:0] pixel_y_out;
    logic [PIXEL_BITS-1:0]  pixel_out;
    logic                   frame_start_out;

    modport master (
        output h_sync_out, v_sync_out, video_on_out,
        output pixel_x_out, pixel_y_out, pixel_out, frame_start_out
    );

    modport slave (
        input h_sync_out, v_sync_out, video_on_out,
        input pixel_x_out, pixel_y_out, pixel_out, frame_start_out
    );
endinterface

// File: rtl/vga_pattern_generator.sv
// Combinational test-pattern lookup: (x, y, pattern) -> 12-bit {R,G,B} pixel.
// Latency: 0 cycles (pure combinational; the parent registers the result).
// Backpressure: none.
module vga_pattern_generator
    import vga_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int COUNT_BITS = 10,
    parameter int PIXEL_BITS = 12
) (
    input  logic [COUNT_BITS-1:0] i_x,
    input  logic [7:0]            i_y,
    input  pattern_t              i_pattern,
    output logic [PIXEL_BITS-1:0] o_pixel
);
    localparam int BAR_W = WIDTH / 8;

    int w_bar;

    // Select the pixel colour for the current coordinate and pattern
    always_comb begin
        w_bar   = int'(i_x) / BAR_W;
        o_pixel = PIXEL_BITS'(COL_BLACK);
        case (i_pattern)
            PAT_BARS: begin
                case (w_bar)
                    0:       o_pixel = PIXEL_BITS'(COL_WHITE);
                    1:       o_pixel = PIXEL_BITS'(COL_YELLOW);
                    2:       o_pixel = PIXEL_BITS'(COL_CYAN);
                    3:       o_pixel = PIXEL_BITS'(COL_GREEN);
                    4:       o_pixel = PIXEL_BITS'(COL_MAGENTA);
                    5:       o_pixel = PIXEL_BITS'(COL_RED);
                    6:       o_pixel = PIXEL_BITS'(COL_BLUE);
                    default: o_pixel = PIXEL_BITS'(COL_BLACK);
                endcase
            end
            PAT_GRID: begin
                if ((i_x[4:0] == 5'd0) || (i_y[4:0] == 5'd0))
                    o_pixel = PIXEL_BITS'(COL_WHITE);
            end
            PAT_GRAD:  o_pixel = PIXEL_BITS'({i_x[7:4], i_y[7:4], i_x[7:4] ^ i_y[7:4]});
            PAT_SOLID: o_pixel = PIXEL_BITS'(COL_BLUE);
            default:   o_pixel = PIXEL_BITS'(COL_BLACK);
        endcase
    end
endmodule

// File: rtl/vga_sync_generator.sv
// VGA timing generator with built-in test patterns; all outputs registered and mutually aligned.
// Latency: 1 enabled clock from (h_count,v_count) to the outputs describing that position.
// Backpressure: none; enable_in is the pixel tick and everything holds while it is low.
module vga_sync_generator
    import vga_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int HEIGHT      = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9,
    parameter int COUNT_BITS  = 10,
    parameter int PIXEL_BITS  = 12
) (
    input  logic                clock_in,
    input  logic                reset_n_in,
    input  logic                enable_in,
    input  logic [1:0]          pattern_sel_in,
    vga_sync_generator_if.master vga
);
    localparam int H_TOTAL = h_total(WIDTH, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(HEIGHT, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COUNT_BITS-1:0] H_LAST   = COUNT_BITS'(H_TOTAL - 1);
    localparam logic [COUNT_BITS-1:0] V_LAST   = COUNT_BITS'(V_TOTAL - 1);
    localparam logic [COUNT_BITS-1:0] H_VIS    = COUNT_BITS'(WIDTH);
    localparam logic [COUNT_BITS-1:0] V_VIS    = COUNT_BITS'(HEIGHT);
    localparam logic [COUNT_BITS-1:0] HS_FIRST = COUNT_BITS'(WIDTH + H_FRONT);
    localparam logic [COUNT_BITS-1:0] HS_LAST  = COUNT_BITS'(WIDTH + H_FRONT + H_SYNC - 1);
    localparam logic [COUNT_BITS-1:0] VS_FIRST = COUNT_BITS'(HEIGHT + V_FRONT);
    localparam logic [COUNT_BITS-1:0] VS_LAST  = COUNT_BITS'(HEIGHT + V_FRONT + V_SYNC - 1);

    logic [COUNT_BITS-1:0]  r_h_count;
    logic [COUNT_BITS-1:0]  r_v_count;
    pattern_t               r_sel;

    logic                   r_h_sync;
    logic                   r_v_sync;
    logic                   r_video_on;
    logic [WIDTH_BITS-1:0]  r_pixel_x;
    logic [HEIGHT_BITS-1:0] r_pixel_y;
    logic [PIXEL_BITS-1:0]  r_pixel;
    logic                   r_frame_start;

    logic                   w_origin;
    logic                   w_video_on;
    logic                   w_h_sync;
    logic                   w_v_sync;
    pattern_t               w_sel;
    logic [PIXEL_BITS-1:0]  w_pixel;

    // Decode the current counter position; the pattern is only re-sampled at the frame origin,
    // and that origin pixel already uses the freshly sampled value.
    assign w_origin   = (r_h_count == '0) && (r_v_count == '0);
    assign w_video_on = (r_h_count < H_VIS) && (r_v_count < V_VIS);
    assign w_h_sync   = !((r_h_count >= HS_FIRST) && (r_h_count <= HS_LAST));
    assign w_v_sync   = !((r_v_count >= VS_FIRST) && (r_v_count <= VS_LAST));
    assign w_sel      = w_origin ? pattern_t'(pattern_sel_in) : r_sel;

    vga_pattern_generator #(
        .WIDTH      (WIDTH),
        .COUNT_BITS (COUNT_BITS),
        .PIXEL_BITS (PIXEL_BITS)
    ) u_pattern (
        .i_x       (r_h_count),
        .i_y       (r_v_count[7:0]),
        .i_pattern (w_sel),
        .o_pixel   (w_pixel)
    );

    // Register outputs from the current position, then advance the raster counters
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_h_count     <= '0;
            r_v_count     <= '0;
            r_sel         <= PAT_BARS;
            r_h_sync      <= 1'b1;
            r_v_sync      <= 1'b1;
            r_video_on    <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_pixel       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            // frame_start is a single-clock pulse even if the next tick is far away
            r_frame_start <= 1'b0;
            if (enable_in) begin
                r_h_sync      <= w_h_sync;
                r_v_sync      <= w_v_sync;
                r_video_on    <= w_video_on;
                r_pixel_x     <= r_h_count[WIDTH_BITS-1:0];
                r_pixel_y     <= r_v_count[HEIGHT_BITS-1:0];
                r_pixel       <= w_video_on ? w_pixel : '0;
                r_frame_start <= w_origin;
                if (w_origin)
                    r_sel <= w_sel;
                if (r_h_count == H_LAST) begin
                    r_h_count <= '0;
                    r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + 1'b1;
                end else begin
                    r_h_count <= r_h_count + 1'b1;
                end
            end
        end
    end

    assign vga.h_sync_out      = r_h_sync;
    assign vga.v_sync_out      = r_v_sync;
    assign vga.video_on_out    = r_video_on;
    assign vga.pixel_x_out     = r_pixel_x;
    assign vga.pixel_y_out     = r_pixel_y;
    assign vga.pixel_out       = r_pixel;
    assign vga.frame_start_out = r_frame_start;
endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a full 640x480 instance and a reduced-geometry instance
// share the same inputs; both are compared every tick against a raster-level reference model.
// Backpressure: n/a.
module tb_vga_sync_generator;
    localparam int S_W = 128, S_HF = 8, S_HS = 16, S_HB = 8;
    localparam int S_H = 64,  S_VF = 4, S_VS = 2,  S_VB = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] sel = 2'd0;

    always #5 clk = ~clk;

    vga_sync_generator_if if_big ();
    vga_sync_generator_if if_small ();

    vga_sync_generator u_big (
        .clock_in       (clk),
        .reset_n_in     (rst_n),
        .enable_in      (en),
        .pattern_sel_in (sel),
        .vga            (if_big)
    );

    vga_sync_generator #(
        .WIDTH (S_W), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .HEIGHT(S_H), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
    ) u_small (
        .clock_in       (clk),
        .reset_n_in     (rst_n),
        .enable_in      (en),
        .pattern_sel_in (sel),
        .vga            (if_small)
    );

    logic [34:0] dut_vec [2];
    assign dut_vec[0] = {if_big.h_sync_out, if_big.v_sync_out, if_big.video_on_out,
                         if_big.pixel_x_out, if_big.pixel_y_out, if_big.pixel_out, if_big.frame_start_out};
    assign dut_vec[1] = {if_small.h_sync_out, if_small.v_sync_out, if_small.video_on_out,
                         if_small.pixel_x_out, if_small.pixel_y_out, if_small.pixel_out, if_small.frame_start_out};

    // Geometry of instance 0 (full VGA) and instance 1 (reduced)
    int gw [2]  = '{640, S_W};
    int ghf[2]  = '{16,  S_HF};
    int ghs[2]  = '{96,  S_HS};
    int ghb[2]  = '{48,  S_HB};
    int gh [2]  = '{480, S_H};
    int gvf[2]  = '{10,  S_VF};
    int gvs[2]  = '{2,   S_VS};
    int gvb[2]  = '{33,  S_VB};

    // Reference model state: raster position about to be shown, latched pattern, expected outputs
    int          mh[2], mv[2], msel[2];
    logic        e_hs[2], e_vs[2], e_von[2], e_fs[2];
    logic [9:0]  e_x[2];
    logic [8:0]  e_y[2];
    logic [11:0] e_pix[2];

    logic [34:0] reset_vec = {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 12'd0, 1'b0};

    int errors = 0;
    int checks = 0;

    function automatic logic [11:0] pattern_ref(input int p, input int x, input int y, input int w);
        if (p == 0) begin
            case (x / (w / 8))
                0: return 12'hFFF;
                1: return 12'hFF0;
                2: return 12'h0FF;
                3: return 12'h0F0;
                4: return 12'hF0F;
                5: return 12'hF00;
                6: return 12'h00F;
                default: return 12'h000;
            endcase
        end
        if (p == 1) return ((x % 32 == 0) || (y % 32 == 0)) ? 12'hFFF : 12'h000;
        if (p == 2) return {4'((x / 16) % 16), 4'((y / 16) % 16), 4'(((x / 16) ^ (y / 16)) % 16)};
        return 12'h00F;
    endfunction

    function automatic logic [34:0] exp_vec(input int k);
        return {e_hs[k], e_vs[k], e_von[k], e_x[k], e_y[k], e_pix[k], e_fs[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mh[k] = 0; mv[k] = 0; msel[k] = 0;
            e_hs[k] = 1'b1; e_vs[k] = 1'b1; e_von[k] = 1'b0; e_fs[k] = 1'b0;
            e_x[k] = '0; e_y[k] = '0; e_pix[k] = '0;
        end
    endtask

    task automatic model_edge(input logic e, input logic [1:0] s);
        int ht, vt, hs0, vs0;
        for (int k = 0; k < 2; k++) begin
            e_fs[k] = 1'b0;
            if (e) begin
                ht  = gw[k] + ghf[k] + ghs[k] + ghb[k];
                vt  = gh[k] + gvf[k] + gvs[k] + gvb[k];
                hs0 = gw[k] + ghf[k];
                vs0 = gh[k] + gvf[k];
                if (mh[k] == 0 && mv[k] == 0) msel[k] = int'(s);
                e_fs[k]  = (mh[k] == 0 && mv[k] == 0);
                e_von[k] = (mh[k] < gw[k]) && (mv[k] < gh[k]);
                e_hs[k]  = !(mh[k] >= hs0 && mh[k] < hs0 + ghs[k]);
                e_vs[k]  = !(mv[k] >= vs0 && mv[k] < vs0 + gvs[k]);
                e_x[k]   = 10'(mh[k]);
                e_y[k]   = 9'(mv[k]);
                e_pix[k] = e_von[k] ? pattern_ref(msel[k], mh[k], mv[k], gw[k]) : 12'h000;
                mh[k] = mh[k] + 1;
                if (mh[k] == ht) begin
                    mh[k] = 0;
                    mv[k] = (mv[k] + 1 == vt) ? 0 : mv[k] + 1;
                end
            end
        end
    endtask

    task automatic tick(input logic e);
        en = e;
        @(posedge clk);
        model_edge(e, sel);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sel = 2'd0;
        en  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec[k] !== reset_vec) begin
                errors++;
                $display("FAIL reset_state inst=%0d got=%h exp=%h", k, dut_vec[k], reset_vec);
            end
        end
        rst_n = 1'b1;
        tick(1'b1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec[k] !== {1'b1, 1'b1, 1'b1, 10'd0, 9'd0, 12'hFFF, 1'b1}) begin
                errors++;
                $display("FAIL first_edge inst=%0d got=%h exp=%h", k, dut_vec[k],
                         {1'b1, 1'b1, 1'b1, 10'd0, 9'd0, 12'hFFF, 1'b1});
            end
        end
    endtask

    task automatic test_line_timing();
        int von_low, von_first, hs_low, hs_first, ht;
        von_low = 0; von_first = -1; hs_low = 0; hs_first = -1;
        ht = gw[0] + ghf[0] + ghs[0] + ghb[0];
        do_reset();
        sel = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2 * ht; i++) begin
            tick(1'b1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_vec[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL line_model inst=%0d got=%h exp=%h", k, dut_vec[k], exp_vec(k));
                end
            end
            if (i < ht) begin
                if (!if_big.video_on_out) begin
                    von_low++;
                    if (von_first < 0) von_first = i;
                end
                if (!if_big.h_sync_out) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = i;
                end
            end
        end
        checks++;
        if (von_low != ht - gw[0] || von_first != gw[0]) begin
            errors++;
            $display("FAIL line_blank got count=%0d first=%0d exp count=%0d first=%0d",
                     von_low, von_first, ht - gw[0], gw[0]);
        end
        checks++;
        if (hs_low != ghs[0] || hs_first != gw[0] + ghf[0]) begin
            errors++;
            $display("FAIL hsync_window got count=%0d first=%0d exp count=%0d first=%0d",
                     hs_low, hs_first, ghs[0], gw[0] + ghf[0]);
        end
    endtask

    task automatic test_frame();
        int fs_first, fs_second, vs_low, vs_first, i, ht, vt;
        fs_first = -1; fs_second = -1; vs_low = 0; vs_first = -1; i = 0;
        ht = gw[1] + ghf[1] + ghs[1] + ghb[1];
        vt = gh[1] + gvf[1] + gvs[1] + gvb[1];
        do_reset();
        sel = 2'($urandom_range(0, 3));
        while (fs_second < 0 && i < 3 * ht * vt) begin
            tick(1'b1);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_vec[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL frame_model inst=%0d got=%h exp=%h", k, dut_vec[k], exp_vec(k));
                end
            end
            if (if_small.frame_start_out) begin
                if (fs_first < 0) fs_first = i;
                else fs_second = i;
            end
            if (fs_first >= 0 && fs_second < 0 && !if_small.v_sync_out) begin
                vs_low++;
                if (vs_first < 0) vs_first = i;
            end
            i++;
        end
        checks++;
        if (fs_second < 0 || fs_second - fs_first != ht * vt) begin
            errors++;
            $display("FAIL frame_period got=%0d exp=%0d", fs_second - fs_first, ht * vt);
        end
        checks++;
        if (vs_low != gvs[1] * ht || vs_first != (gh[1] + gvf[1]) * ht) begin
            errors++;
            $display("FAIL vsync_window got count=%0d first=%0d exp count=%0d first=%0d",
                     vs_low, vs_first, gvs[1] * ht, (gh[1] + gvf[1]) * ht);
        end
    endtask

    task automatic test_enable_toggle();
        int          fs_clocks[2];
        int          held_bad;
        logic [34:0] prev[2];
        logic        e;
        fs_clocks = '{0, 0};
        held_bad  = 0;
        do_reset();
        sel = 2'($urandom_range(0, 3));
        prev[0] = dut_vec[0];
        prev[1] = dut_vec[1];
        for (int i = 0; i < 400; i++) begin
            e = (i % 2 == 0);
            tick(e);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_vec[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL toggle_model inst=%0d got=%h exp=%h", k, dut_vec[k], exp_vec(k));
                end
                if (dut_vec[k][0]) fs_clocks[k]++;
                if (!e && dut_vec[k][34:1] !== prev[k][34:1]) held_bad++;
                prev[k] = dut_vec[k];
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (fs_clocks[k] != 1) begin
                errors++;
                $display("FAIL frame_start_width inst=%0d got=%0d clocks exp=1", k, fs_clocks[k]);
            end
        end
        checks++;
        if (held_bad != 0) begin
            errors++;
            $display("FAIL hold_when_disabled got=%0d changes exp=0", held_bad);
        end
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 3) == 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_vec[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL sparse_model inst=%0d got=%h exp=%h", k, dut_vec[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_pattern_switch();
        int  i, bars_bad;
        bit  seen00, seen11, seen321;
        i = 0; bars_bad = 0; seen00 = 0; seen11 = 0; seen321 = 0;
        sel = 2'd0;
        do_reset();
        while (!(mh[1] == 100 && mv[1] == 50) && i < 20000) begin
            tick(1'b1);
            i++;
        end
        sel = 2'd1;
        while (!(mh[1] == 0 && mv[1] == 0) && i < 40000) begin
            tick(1'b1);
            i++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_vec[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL switch_model inst=%0d got=%h exp=%h", k, dut_vec[k], exp_vec(k));
                end
            end
            if (if_small.video_on_out &&
                if_small.pixel_out !== pattern_ref(0, int'(if_small.pixel_x_out), 0, gw[1]))
                bars_bad++;
        end
        checks++;
        if (bars_bad != 0 || i >= 40000) begin
            errors++;
            $display("FAIL no_tearing got=%0d non-bar pixels exp=0", bars_bad);
        end
        while (mv[1] < 2 && i < 45000) begin
            tick(1'b1);
            i++;
            if (if_small.video_on_out && if_small.pixel_y_out == 9'd0 && if_small.pixel_x_out == 10'd0) begin
                seen00 = 1;
                checks++;
                if (if_small.pixel_out !== 12'hFFF) begin
                    errors++;
                    $display("FAIL grid_0_0 got=%h exp=fff", if_small.pixel_out);
                end
            end
            if (if_small.video_on_out && if_small.pixel_y_out == 9'd1 && if_small.pixel_x_out == 10'd1) begin
                seen11 = 1;
                checks++;
                if (if_small.pixel_out !== 12'h000) begin
                    errors++;
                    $display("FAIL grid_1_1 got=%h exp=000", if_small.pixel_out);
                end
            end
            if (if_small.video_on_out && if_small.pixel_y_out == 9'd1 && if_small.pixel_x_out == 10'd32) begin
                seen321 = 1;
                checks++;
                if (if_small.pixel_out !== 12'hFFF) begin
                    errors++;
                    $display("FAIL grid_32_1 got=%h exp=fff", if_small.pixel_out);
                end
            end
        end
        checks++;
        if (!(seen00 && seen11 && seen321)) begin
            errors++;
            $display("FAIL grid_points_seen got=%0d%0d%0d exp=111", seen00, seen11, seen321);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        i = 0;
        do_reset();
        sel = 2'($urandom_range(0, 3));
        while (!(e_x[0] == 10'd300 && e_y[0] == 9'd10 && e_von[0]) && i < 20000) begin
            tick(1'b1);
            i++;
        end
        checks++;
        if (if_big.pixel_x_out !== 10'd300 || if_big.pixel_y_out !== 9'd10) begin
            errors++;
            $display("FAIL reach_300_10 got=%0d,%0d exp=300,10", if_big.pixel_x_out, if_big.pixel_y_out);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec[k] !== reset_vec) begin
                errors++;
                $display("FAIL async_reset inst=%0d got=%h exp=%h", k, dut_vec[k], reset_vec);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec[k] !== exp_vec(k) || !dut_vec[k][0] || dut_vec[k][31:13] !== 19'd0) begin
                errors++;
                $display("FAIL restart_origin inst=%0d got=%h exp=%h", k, dut_vec[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 63) == 0) sel = 2'($urandom_range(0, 3));
            tick($urandom_range(0, 3) != 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_vec[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random_model inst=%0d got=%h exp=%h", k, dut_vec[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_enable_toggle();
        test_pattern_switch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
